dmac_channel_scheduler: RTL and testbench

DMAC_CHANNEL_SCHEDULER -- requirements
Module: dmac_channel_scheduler

---
 rtl/dmac_pkg.sv | 14 +
 rtl/dmac_rr_arbiter.sv | 30 +++
 rtl/dmac_channel_scheduler.sv | 115 +++++++++++
 tb/tb_dmac_channel_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared types and sizing for the DMA controller channel scheduler.
package dmac_pkg;

  localparam int unsigned NUM_CH = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    START,
    BUSY,
    ACK
  } sched_state_t;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// Round-robin channel picker: the nearest pending channel after last_served wins.
module dmac_rr_arbiter
  import dmac_pkg::*;
#(
  parameter int unsigned NUM_CH = dmac_pkg::NUM_CH,
  localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CHW-1:0]    last_served,
  output logic              grant_valid,
  output logic [CHW-1:0]    grant_idx
);

  logic [CHW-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest match is the last one kept.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CHW'((32'(last_served) + NUM_CH + 1 - k) % NUM_CH);
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dmac_channel_scheduler.sv
// DMA channel scheduler: picks a requesting channel, acquires the AHB bus,
// sequences the datapath transfer and keeps per-channel completion/error flags.
module dmac_channel_scheduler
  import dmac_pkg::*;
#(
  parameter int unsigned NUM_CH = dmac_pkg::NUM_CH,
  localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] DmacReq,
  input  logic [NUM_CH-1:0] ChEnable,
  input  logic              Bus_Grant,
  input  logic              ChDone,
  input  logic              ChError,
  input  logic [NUM_CH-1:0] IntClr,
  output logic              Bus_Req,
  output logic [CHW-1:0]    ChSel,
  output logic              ChStart,
  output logic              ChHold,
  output logic [NUM_CH-1:0] ReqAck,
  output logic [NUM_CH-1:0] IntStatus,
  output logic [NUM_CH-1:0] ErrStatus,
  output logic              Interrupt
);

  sched_state_t      state;
  logic [CHW-1:0]    last_served;
  logic [NUM_CH-1:0] pending;
  logic              grant_valid;
  logic [CHW-1:0]    grant_idx;
  logic              finish;
  logic [NUM_CH-1:0] sel_vec;
  logic [NUM_CH-1:0] int_set;
  logic [NUM_CH-1:0] err_set;
  logic [NUM_CH-1:0] int_next;
  logic [NUM_CH-1:0] err_next;

  assign pending = DmacReq & ChEnable;

  dmac_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .pending    (pending),
    .last_served(last_served),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign finish = (state == BUSY) && (ChDone || ChError);

  always_comb begin
    sel_vec        = '0;
    sel_vec[ChSel] = 1'b1;
    int_set        = finish ? sel_vec : '0;
    err_set        = (finish && ChError) ? sel_vec : '0;
    int_next       = (IntStatus & ~IntClr) | int_set;
    err_next       = (ErrStatus & ~IntClr) | err_set;
  end

  // Stall follows the live grant so the datapath freezes in the same cycle the bus is lost.
  assign ChHold = (state == BUSY) && !Bus_Grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= CHW'(NUM_CH - 1);
      Bus_Req     <= 1'b0;
      ChSel       <= '0;
      ChStart     <= 1'b0;
      ReqAck      <= '0;
      IntStatus   <= '0;
      ErrStatus   <= '0;
      Interrupt   <= 1'b0;
    end else begin
      IntStatus <= int_next;
      ErrStatus <= err_next;
      Interrupt <= (|int_next) | (|err_next);
      ChStart   <= 1'b0;
      ReqAck    <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            ChSel   <= grant_idx;
            Bus_Req <= 1'b1;
            state   <= WAIT_GRANT;
          end
        end
        WAIT_GRANT: begin
          if (Bus_Grant) begin
            ChStart <= 1'b1;
            state   <= START;
          end
        end
        START: state <= BUSY;
        BUSY: begin
          if (finish) begin
            Bus_Req <= 1'b0;
            ReqAck  <= sel_vec;
            state   <= ACK;
          end
        end
        ACK: begin
          last_served <= ChSel;
          state       <= IDLE;
        end
        default: begin
          Bus_Req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_channel_scheduler.sv
// Directed bench for dmac_channel_scheduler: a vector table for the basic
// single-channel flow plus hand-written multi-cycle sequences.
module tb_dmac_channel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] DmacReq;
  logic [1:0] ChEnable;
  logic       Bus_Grant;
  logic       ChDone;
  logic       ChError;
  logic [1:0] IntClr;
  logic       Bus_Req;
  logic       ChSel;
  logic       ChStart;
  logic       ChHold;
  logic [1:0] ReqAck;
  logic [1:0] IntStatus;
  logic [1:0] ErrStatus;
  logic       Interrupt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmac_channel_scheduler #(
    .NUM_CH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .DmacReq  (DmacReq),
    .ChEnable (ChEnable),
    .Bus_Grant(Bus_Grant),
    .ChDone   (ChDone),
    .ChError  (ChError),
    .IntClr   (IntClr),
    .Bus_Req  (Bus_Req),
    .ChSel    (ChSel),
    .ChStart  (ChStart),
    .ChHold   (ChHold),
    .ReqAck   (ReqAck),
    .IntStatus(IntStatus),
    .ErrStatus(ErrStatus),
    .Interrupt(Interrupt)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  en;
    logic        grant;
    logic        done;
    logic        err;
    logic [1:0]  clr;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Output packing: {Bus_Req, ChSel, ChStart, ChHold, ReqAck, IntStatus, ErrStatus, Interrupt}
  function automatic logic [10:0] outs();
    return {Bus_Req, ChSel, ChStart, ChHold, ReqAck, IntStatus, ErrStatus, Interrupt};
  endfunction

  function automatic logic [10:0] mk(input logic b, input logic s, input logic st, input logic h,
                                     input logic [1:0] a, input logic [1:0] i,
                                     input logic [1:0] e, input logic q);
    return {b, s, st, h, a, i, e, q};
  endfunction

  task automatic add(input logic [1:0] req, input logic [1:0] en, input logic grant,
                     input logic done, input logic err, input logic [1:0] clr,
                     input logic [10:0] exp);
    vec_t v;
    v.req = req; v.en = en; v.grant = grant; v.done = done; v.err = err; v.clr = clr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 10 && ChStart !== 1'b1; i++) tick();
    chk(name, 32'(ChStart), 32'd1);
  endtask

  // From the START cycle: one BUSY cycle, then a done/error pulse; returns in ACK.
  task automatic finish_transfer(input logic err);
    tick();
    ChDone  = 1'b1;
    ChError = err;
    tick();
    ChDone  = 1'b0;
    ChError = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold_cnt;
    rst = 1'b1; DmacReq = '0; ChEnable = '0; Bus_Grant = 1'b0;
    ChDone = 1'b0; ChError = 1'b0; IntClr = '0;

    // Masked request, stray done/error in IDLE, then a single ch0 transfer with
    // ChDone five cycles after ChStart and a clear of the completion flag.
    add(2'b10, 2'b01, 1, 0, 0, 2'b00, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(2'b10, 2'b01, 1, 0, 0, 2'b00, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(2'b00, 2'b11, 1, 1, 1, 2'b00, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(2'b01, 2'b11, 1, 0, 0, 2'b00, mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(2'b01, 2'b11, 1, 0, 0, 2'b00, mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
    for (int i = 0; i < 5; i++)
      add(2'b00, 2'b11, 1, 0, 0, 2'b00, mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add(2'b00, 2'b11, 1, 1, 0, 2'b00, mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 1));
    add(2'b00, 2'b11, 1, 0, 0, 2'b00, mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1));
    add(2'b00, 2'b11, 1, 0, 0, 2'b01, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));

    do_reset();
    chk("reset_state", 32'(outs()), 32'd0);

    foreach (vecs[i]) begin
      DmacReq = vecs[i].req; ChEnable = vecs[i].en; Bus_Grant = vecs[i].grant;
      ChDone = vecs[i].done; ChError = vecs[i].err; IntClr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    ChDone = 1'b0; ChError = 1'b0; IntClr = '0;

    // Tie: channel 0 first after reset, then channel 1.
    do_reset();
    DmacReq = 2'b11; ChEnable = 2'b11; Bus_Grant = 1'b1;
    tick();
    chk("tie_sel_first", 32'(ChSel), 32'd0);
    wait_start("tie_start_first");
    finish_transfer(1'b0);
    chk("tie_ack_first", 32'(ReqAck), 32'h1);
    tick();
    chk("tie_idle_busreq", 32'(Bus_Req), 32'd0);
    tick();
    chk("tie_sel_second", 32'(ChSel), 32'd1);
    wait_start("tie_start_second");
    finish_transfer(1'b0);
    chk("tie_ack_second", 32'(ReqAck), 32'h2);
    chk("tie_int_both", 32'(IntStatus), 32'h3);
    DmacReq = '0; IntClr = 2'b11;
    tick();
    IntClr = '0;
    chk("tie_int_cleared", 32'(IntStatus), 32'h0);

    // Done and error together on channel 1, cleared the following cycle.
    DmacReq = 2'b10;
    tick();
    chk("err_sel", 32'(ChSel), 32'd1);
    wait_start("err_start");
    finish_transfer(1'b1);
    chk("err_flags", 32'({IntStatus, ErrStatus, Interrupt}), 32'b10101);
    DmacReq = '0; IntClr = 2'b10;
    tick();
    IntClr = '0;
    chk("err_cleared", 32'({IntStatus, ErrStatus, Interrupt}), 32'b00000);

    // Grant withheld for four WAIT_GRANT cycles, then lost for three BUSY cycles.
    Bus_Grant = 1'b0; DmacReq = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gw_busreq%0d", i), 32'(Bus_Req), 32'd1);
      chk($sformatf("gw_nostart%0d", i), 32'(ChStart), 32'd0);
      if (i < 3) tick();
    end
    Bus_Grant = 1'b1;
    tick();
    chk("gw_start", 32'({Bus_Req, ChStart}), 32'b11);
    DmacReq = '0;
    tick();
    hold_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      Bus_Grant = (i == 0);
      if (i == 3) begin
        ChDone = 1'b1;
        IntClr = 2'b01;
      end
      #1;
      if (ChHold === 1'b1) hold_cnt++;
      chk($sformatf("gl_busreq%0d", i), 32'(Bus_Req), 32'd1);
      tick();
    end
    ChDone = 1'b0; IntClr = '0; Bus_Grant = 1'b1;
    chk("gl_hold_cycles", 32'(hold_cnt), 32'd3);
    chk("gl_ack", 32'(ReqAck), 32'h1);
    chk("gl_set_wins", 32'(IntStatus), 32'h1);
    chk("gl_hold_released", 32'(ChHold), 32'd0);
    tick();

    // Reset in BUSY with a done pulse pending: everything clears, no acknowledge.
    DmacReq = 2'b01;
    tick();
    wait_start("rst_start");
    tick();
    chk("rst_busy_busreq", 32'(Bus_Req), 32'd1);
    rst = 1'b1; ChDone = 1'b1;
    tick();
    chk("rst_outputs", 32'(outs()), 32'd0);
    rst = 1'b0; ChDone = 1'b0; DmacReq = '0;
    tick();
    chk("rst_no_ack", 32'(outs()), 32'd0);

    // last_served must return to 1 so channel 0 wins the tie again.
    DmacReq = 2'b11;
    tick();
    chk("rst_tie_sel", 32'({Bus_Req, ChSel}), 32'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0; DmacReq = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
